dff_register_arbiter: RTL and testbench

- Arbitrates write access to a shared DATA_WIDTH-bit D-flip-flop register bank among NUM_REQ requesters.
- Requesters are typically push-button or switch-driven circuits in a wiRedPanda design.
- A round-robin FSM grants one requester at a time and holds the grant for a fixed settle window.
- It then clocks the owner's data into the bank, pulses an acknowledge, and waits for the owner to release before re-arbitrating. Q/Qn drive LEDs or downstream logic.

---
 rtl/dff_register_arbiter.sv | 132 +++++++++++++
 tb/tb_dff_register_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_register_arbiter.sv
// Round-robin arbiter guarding a shared DFF register bank: grant, settle HOLD_CYCLES, write, ack, wait for release.
// Grant appears 1 edge after request; q/ack update HOLD_CYCLES edges after the request is sampled; all outputs are flops.
module dff_register_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          input_clock1_1,
  input  logic                          input_reset_n,
  input  logic [NUM_REQ-1:0]            input_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] input_data,
  output logic [NUM_REQ-1:0]            output_grant,
  output logic [NUM_REQ-1:0]            output_ack,
  output logic [DATA_WIDTH-1:0]         output_q,
  output logic [DATA_WIDTH-1:0]         output_qn,
  output logic                          output_busy,
  output logic [OW-1:0]                 output_owner
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [OW-1:0]         r_owner;
  logic [OW-1:0]         r_last_owner;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_qn;
  logic                  r_busy;

  logic                  w_any;
  logic [OW-1:0]         w_sel;
  logic [NUM_REQ-1:0]    w_sel_oh;
  logic [NUM_REQ-1:0]    w_owner_oh;
  logic                  w_owner_req;
  logic [DATA_WIDTH-1:0] w_slices [NUM_REQ];

  // Scan starts just past the last owner, so a freshly served or aborted requester goes to the back.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_last_owner) + k) % NUM_REQ;
      if (!w_any && input_req[OW'(idx)]) begin
        w_any = 1'b1;
        w_sel = OW'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slices[i] = input_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_sel_oh    = NUM_REQ'(1) << w_sel;
  assign w_owner_oh  = NUM_REQ'(1) << r_owner;
  assign w_owner_req = input_req[r_owner];

  always_ff @(posedge input_clock1_1 or negedge input_reset_n) begin
    if (!input_reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
      r_grant      <= '0;
      r_ack        <= '0;
      r_q          <= '0;
      r_qn         <= '1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner      <= w_sel;
            r_last_owner <= w_sel;
            r_grant      <= w_sel_oh;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'(HOLD_CYCLES - 1)) begin
            r_q     <= w_slices[r_owner];
            r_qn    <= ~w_slices[r_owner];
            r_ack   <= w_owner_oh;
            r_state <= ST_WRITE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_WRITE: begin
          r_ack   <= '0;
          r_grant <= '0;
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Other requesters wait until the owner lets go; no re-arbitration from here.
          if (!w_owner_req) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign output_grant = r_grant;
  assign output_ack   = r_ack;
  assign output_q     = r_q;
  assign output_qn    = r_qn;
  assign output_busy  = r_busy;
  assign output_owner = r_owner;

endmodule

// File: tb/tb_dff_register_arbiter.sv
// Directed bench for dff_register_arbiter (NUM_REQ=4, DATA_WIDTH=4, HOLD_CYCLES=2).
module tb_dff_register_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [3:0]  q;
  logic [3:0]  qn;
  logic        busy;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  dff_register_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (4),
    .HOLD_CYCLES(2)
  ) dut (
    .input_clock1_1(clk),
    .input_reset_n (rst_n),
    .input_req     (req),
    .input_data    (data),
    .output_grant  (grant),
    .output_ack    (ack),
    .output_q      (q),
    .output_qn     (qn),
    .output_busy   (busy),
    .output_owner  (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, settle, and check the one-hot invariants every cycle.
  task automatic step();
    @(posedge clk);
    #2;
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    chk("ack_onehot0", 32'($onehot0(ack)), 1);
  endtask

  task automatic set_data(input int k, input logic [3:0] v);
    data[k*4 +: 4] = v;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = '0;

    // 1. reset state, then a single request
    step(); step(); step();
    chk("rst_q", 32'(q), 'h0);
    chk("rst_qn", 32'(qn), 'hF);
    chk("rst_grant", 32'(grant), 'h0);
    chk("rst_ack", 32'(ack), 'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    rst_n = 1'b1;
    req   = 4'b0001;
    set_data(0, 4'hA);
    step();
    chk("t1_grant_e1", 32'(grant), 'b0001);
    chk("t1_busy_e1", 32'(busy), 1);
    chk("t1_q_e1", 32'(q), 'h0);
    step();
    chk("t1_ack_e2", 32'(ack), 'h0);
    step();
    chk("t1_q_e3", 32'(q), 'hA);
    chk("t1_qn_e3", 32'(qn), 'h5);
    chk("t1_ack_e3", 32'(ack), 'b0001);
    chk("t1_grant_e3", 32'(grant), 'b0001);
    step();
    chk("t1_ack_e4", 32'(ack), 'h0);
    chk("t1_grant_e4", 32'(grant), 'h0);
    chk("t1_busy_e4", 32'(busy), 1);
    req = 4'b0000;
    step();
    chk("t1_busy_e5", 32'(busy), 0);

    // 2. simultaneous requests from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b1010;
    set_data(1, 4'h3);
    set_data(3, 4'hC);
    step();
    chk("t2_grant_a", 32'(grant), 'b0010);
    chk("t2_owner_a", 32'(owner), 1);
    step(); step();
    chk("t2_q_a", 32'(q), 'h3);
    chk("t2_ack_a", 32'(ack), 'b0010);
    req = 4'b1000;
    step();
    chk("t2_grant_rel", 32'(grant), 'h0);
    step();
    chk("t2_busy_idle", 32'(busy), 0);
    step();
    chk("t2_grant_b", 32'(grant), 'b1000);
    chk("t2_owner_b", 32'(owner), 3);
    step(); step();
    chk("t2_q_b", 32'(q), 'hC);
    chk("t2_ack_b", 32'(ack), 'b1000);
    req = 4'b0000;
    step(); step();
    chk("t2_busy_end", 32'(busy), 0);

    // 3. round-robin with wrap, every requester pending
    for (int k = 0; k < 4; k++) set_data(k, 4'(1 << k));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = order[n];
      step();
      chk("t3_grant", 32'(grant), 32'(1 << k));
      chk("t3_owner", 32'(owner), 32'(k));
      step(); step();
      chk("t3_ack", 32'(ack), 32'(1 << k));
      chk("t3_q", 32'(q), 32'(1 << k));
      req[k] = 1'b0;
      step();
      chk("t3_rel_grant", 32'(grant), 0);
      chk("t3_rel_busy", 32'(busy), 1);
      step();
      chk("t3_idle_busy", 32'(busy), 0);
      req[k] = 1'b1;
    end
    req = 4'b0000;

    // 4. abort during GRANT, aborted requester loses priority
    req = 4'b0100;
    step();
    chk("t4_grant", 32'(grant), 'b0100);
    chk("t4_owner", 32'(owner), 2);
    req = 4'b0000;
    step();
    chk("t4_abort_grant", 32'(grant), 0);
    chk("t4_abort_busy", 32'(busy), 0);
    chk("t4_abort_ack", 32'(ack), 0);
    chk("t4_abort_q", 32'(q), 'h1);
    req = 4'b1100;
    step();
    chk("t4_next_grant", 32'(grant), 'b1000);
    chk("t4_next_owner", 32'(owner), 3);
    step(); step();
    chk("t4_next_ack", 32'(ack), 'b1000);
    chk("t4_next_q", 32'(q), 'h8);
    req = 4'b0000;
    step(); step();

    // 5. asynchronous reset while ack is high
    set_data(0, 4'h6);
    req = 4'b0001;
    step(); step(); step();
    chk("t5_ack_before", 32'(ack), 'b0001);
    chk("t5_q_before", 32'(q), 'h6);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_ack_async", 32'(ack), 0);
    chk("t5_grant_async", 32'(grant), 0);
    chk("t5_busy_async", 32'(busy), 0);
    chk("t5_q_async", 32'(q), 0);
    chk("t5_qn_async", 32'(qn), 'hF);
    req = 4'b0011;
    step();
    rst_n = 1'b1;

    // 6. owner holds req in RELEASE while req1 waits
    step();
    chk("t6_grant0", 32'(grant), 'b0001);
    chk("t6_owner0", 32'(owner), 0);
    step(); step();
    chk("t6_ack0", 32'(ack), 'b0001);
    chk("t6_q0", 32'(q), 'h6);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t6_hold_busy", 32'(busy), 1);
      chk("t6_hold_grant", 32'(grant), 0);
    end
    req = 4'b0010;
    step();
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_grant", 32'(grant), 0);
    step();
    chk("t6_grant1", 32'(grant), 'b0010);
    chk("t6_owner1", 32'(owner), 1);
    step(); step();
    chk("t6_ack1", 32'(ack), 'b0010);
    chk("t6_q1", 32'(q), 'h2);
    chk("t6_qn1", 32'(qn), 'hD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
